// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the TDM demultiplexer
package tdm_pkg;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Slot index width; never below 1 so the counter always has a bit.
  function automatic int SLOT_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - link input and per-channel output bundle for tdm_demux
interface tdm_demux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);
  logic [W-1:0]      din;
  logic              din_valid;
  logic              frame_sync;
  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic              frame_done;
  logic              locked;
  logic              sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch_data, ch_valid, frame_done, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_data, ch_valid, frame_done, locked, sync_err
  );
endinterface

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - mod-N_CH slot counter with clear and load-to-one
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    load1,
  input  logic                    clr,
  output logic [SLOT_W(N_CH)-1:0] slot,
  output logic                    is_last
);
  localparam int             SW   = SLOT_W(N_CH);
  localparam logic [SW-1:0]  LAST = SW'(N_CH - 1);

  assign is_last = (slot == LAST);

  // Wraps at N_CH-1 so non-power-of-2 channel counts never reach N_CH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SW'(1);
    end else if (inc) begin
      slot <= is_last ? '0 : slot + 1'b1;
    end
  end
endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - frame-locked TDM receiver steering slot words into channel registers
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) (
  input logic         clk,
  input logic         rst,
  tdm_demux_if.slave  bus
);
  localparam int SW = SLOT_W(N_CH);

  generate
    if (N_CH < 2) begin : g_bad_n_ch
      $error("tdm_demux requires N_CH >= 2");
    end
  endgenerate

  state_t          state;
  state_t          state_n;
  logic [SW-1:0]   slot;
  logic            is_last;
  logic            wr_en;
  logic [SW-1:0]   wr_idx;
  logic            inc;
  logic            load1;
  logic            clr;
  logic            err;
  logic            fdone;

  tdm_slot_counter #(.N_CH(N_CH)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .load1   (load1),
    .clr     (clr),
    .slot    (slot),
    .is_last (is_last)
  );

  // Sync always realigns to slot 0; early sync abandons the partial frame.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    inc     = 1'b0;
    load1   = 1'b0;
    clr     = 1'b0;
    err     = 1'b0;
    fdone   = 1'b0;
    state_n = state;
    if (bus.din_valid) begin
      case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en   = 1'b1;
            load1   = 1'b1;
            state_n = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync) begin
            wr_en = 1'b1;
            load1 = 1'b1;
            err   = (slot != '0);
          end else if (slot == '0) begin
            err     = 1'b1;
            clr     = 1'b1;
            state_n = HUNT;
          end else begin
            wr_en  = 1'b1;
            wr_idx = slot;
            inc    = 1'b1;
            fdone  = is_last;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HUNT;
      bus.ch_data    <= '0;
      bus.ch_valid   <= '0;
      bus.frame_done <= 1'b0;
      bus.locked     <= 1'b0;
      bus.sync_err   <= 1'b0;
    end else begin
      state          <= state_n;
      bus.ch_valid   <= '0;
      bus.frame_done <= fdone;
      bus.locked     <= (state_n == LOCKED);
      bus.sync_err   <= err;
      for (int k = 0; k < N_CH; k++) begin
        if (wr_en && (wr_idx == SW'(k))) begin
          bus.ch_data[k*W +: W] <= bus.din;
          bus.ch_valid[k]       <= 1'b1;
        end
      end
    end
  end
endmodule
